spi_shifter: RTL
================

# spi_shifter

Bit-level SPI transfer engine that sits directly downstream of the `spi_master` register front-end. The front-end latches a byte and the mode bits, then pulses `i_start`. This block generates SCLK, serialises the byte MSB-first on MOSI, samples MISO into a receive byte, and reports `o_busy` and `o_done` back. Slave-select stays in the front-end; this block never touches SS.

## Interface
- `CLK_FREQ`, default 48_000_000: system clock frequency in Hz.
- `SCLK_FREQ`, default 1_000_000: target SCLK frequency in Hz.
  - `HALF = CLK_FREQ/(2*SCLK_FREQ)`, in system clocks per SCLK half-period.
  - `HALF` must be at least 2. Elaboration fails otherwise.
- `i_clk`  input  1  system clock; all logic on its rising edge.
- `i_rst`  input  1  reset, asynchronous, active-high.
- `i_start`  input  1  single-cycle request to begin a transfer.
- `i_data`  input  8  byte to transmit; captured when the start is accepted.
- `i_cpol`  input  1  clock polarity (idle level of SCLK).
- `i_cpha`  input  1  clock phase (0: sample on leading edge; 1: sample on trailing edge).
- `o_busy`  output  1  high while a transfer is in progress.
- `o_done`  output  1  one-cycle pulse when a transfer completes.
- `o_data`  output  8  last received byte; holds until the next `o_done`.
- `o_SCLK`  output  1  SPI clock.
- `o_MOSI`  output  1  master out.
- `i_MISO`  input  1  master in; sampled directly, with no synchroniser.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE:**
  - `o_SCLK` follows registered `i_cpol`, with one cycle of lag.
  - When `i_start` is high, the start is accepted:
    - latch `i_data` into the tx shift register, and latch `i_cpol`/`i_cpha`;
    - clear the edge counter (5 bits, 0..16) and load the divider with `HALF-1`;
    - set `o_busy`;
    - if CPHA=0, drive `o_MOSI` = `i_data[7]`;
    - go to SHIFT.
- **SHIFT:**
  - The divider counts down. When it reaches 0 it reloads `HALF-1`, toggles `o_SCLK` and increments the edge number k (1..16).
  - Odd k is a leading edge; even k is a trailing edge.
  - CPHA=0: on odd k, sample MISO into rx LSB and shift rx left. On even k < 16, drive the next tx bit on MOSI.
  - CPHA=1: on odd k, drive the next tx bit (bit 7 first) on MOSI. On even k, sample MISO.
  - Exactly 8 samples and 16 edges occur per byte. After k=16, `o_SCLK` equals the latched CPOL.
  - After k=16, go to DONE.
- **DONE (one cycle):**
  - `o_data` ← rx byte.
  - `o_done`=1 and `o_busy`=0.
  - Back-to-back: `i_start` in this cycle is accepted exactly as in IDLE.
  - Otherwise go to IDLE.
- `i_start` while in SHIFT is ignored, with no queueing.
- `i_data`, `i_cpol` and `i_cpha` changes during SHIFT have no effect.
- `o_MOSI` holds its last driven bit after the transfer.
- Reset (any state, including mid-transfer):
  - `o_busy`=0, `o_done`=0, `o_data`=8'h00, `o_SCLK`=0, `o_MOSI`=0.
  - FSM goes to IDLE and latched mode = 00.
  - No `o_done` is issued for an aborted transfer.

## Timing
- All outputs are registered.
- Start accepted at edge 0, so `o_busy`=1 from cycle 1.
- SCLK edge k occurs at cycle k·HALF after acceptance.
- `o_done` is high in cycle 16·HALF+1; `o_busy` is low in that same cycle.
- Total latency from accepted start to `o_done` is 16·HALF+1 cycles.
- MISO is sampled on the same clock as the sampling SCLK edge is registered. Slave output must be stable for one system clock before it, which is guaranteed because HALF ≥ 2.
- MOSI changes on the same clock as the launching SCLK edge, giving a setup of ≥ HALF cycles before the sampling edge.

## Structure
- Shared include `spi_defs.vh`:
  - mode encodings (MODE0..MODE3 = {CPOL,CPHA});
  - the `HALF` derivation macro;
  - the register addresses used by the front-end.
- One sub-module, `spi_clkgen`: divider with `HALF` parameter, enable input, and one-cycle `tick` output; resets to `HALF-1`.
- The FSM, shift registers and edge counter live in `spi_shifter`.

## Test plan
All scenarios use `HALF`=2, with a loopback model slave unless stated.
- Mode 0, `i_data`=8'hA5, slave returns 8'h3C:
  - MOSI bits 1,0,1,0,0,1,0,1 stable at each rising SCLK;
  - `o_done` at cycle 33;
  - `o_data`=8'h3C.
- Mode 3, `i_data`=8'h81, slave returns 8'hFF:
  - SCLK idles high and ends high after 16 edges;
  - `o_data`=8'hFF;
  - exactly 8 samples counted.
- Modes 1 and 2 with 8'h5A each way: received byte matches transmitted on both.
- `i_start` pulsed at cycle 10 of a transfer is ignored: a single `o_done`, and `o_busy` is continuous.
- `i_start` asserted during the `o_done` cycle: the second transfer starts with no idle cycle, and its `o_done` follows 33 cycles later.
- `i_rst` asserted at cycle 15 mid-transfer:
  - all outputs return to reset values asynchronously;
  - no `o_done`;
  - a following start completes normally.

Source files
------------

// File: rtl/spi_shifter_pkg.sv
// Shared definitions for the SPI transfer engine: FSM states, SPI mode
// encodings, front-end register map and the SCLK half-period derivation.
package spi_shifter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // {CPOL, CPHA}
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_STATUS = 2'd1,
        REG_TXDATA = 2'd2,
        REG_RXDATA = 2'd3
    } reg_addr_t;

    localparam logic [4:0] LAST_EDGE = 5'd16;

    function automatic int half_cycles(input int clk_freq, input int sclk_freq);
        return clk_freq / (2 * sclk_freq);
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK half-period divider: while enabled, pulses tick for one clock every
// HALF clocks; held at its reload value while disabled.
module spi_clkgen #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (HALF > 2) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(HALF - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= RELOAD;
        end else if (!en || cnt_reg == '0) begin
            cnt_reg <= RELOAD;
        end else begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign tick = en && (cnt_reg == '0);

endmodule

// File: rtl/spi_shifter.sv
// Bit-level SPI engine: generates SCLK, shifts a byte out MSB-first on MOSI
// and collects eight MISO samples, for any of the four CPOL/CPHA modes.
module spi_shifter
    import spi_shifter_pkg::*;
#(
    parameter int CLK_FREQ  = 48_000_000,
    parameter int SCLK_FREQ = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_cpol,
    input  logic       i_cpha,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_data,
    output logic       o_SCLK,
    output logic       o_MOSI,
    input  logic       i_MISO
);

    localparam int HALF = half_cycles(CLK_FREQ, SCLK_FREQ);

    generate
        if (HALF < 2) begin : g_half_check
            $error("spi_shifter: CLK_FREQ/(2*SCLK_FREQ) must be at least 2");
        end
    endgenerate

    state_t     state_reg, state_next;
    logic [7:0] tx_reg, tx_next;
    logic [7:0] rx_reg, rx_next;
    logic [4:0] edge_reg, edge_next;
    spi_mode_t  mode_reg, mode_next;
    logic       sclk_reg, sclk_next;
    logic       mosi_reg, mosi_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic [7:0] data_reg, data_next;
    logic       tick;
    logic [4:0] edge_k;

    assign edge_k = edge_reg + 5'd1;

    spi_clkgen #(.HALF(HALF)) u_clkgen (
        .clk  (i_clk),
        .rst  (i_rst),
        .en   (state_reg == ST_SHIFT),
        .tick (tick)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            tx_reg    <= 8'h00;
            rx_reg    <= 8'h00;
            edge_reg  <= 5'd0;
            mode_reg  <= MODE0;
            sclk_reg  <= 1'b0;
            mosi_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            data_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            tx_reg    <= tx_next;
            rx_reg    <= rx_next;
            edge_reg  <= edge_next;
            mode_reg  <= mode_next;
            sclk_reg  <= sclk_next;
            mosi_reg  <= mosi_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: state_next = i_start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT:         if (tick && edge_k == LAST_EDGE) state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_next   = tx_reg;
        rx_next   = rx_reg;
        edge_next = edge_reg;
        mode_next = mode_reg;
        sclk_next = sclk_reg;
        mosi_next = mosi_reg;
        busy_next = busy_reg;
        done_next = 1'b0;
        data_next = data_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                sclk_next = i_cpol;
                busy_next = 1'b0;
                if (i_start) begin
                    tx_next   = i_data;
                    rx_next   = 8'h00;
                    mode_next = spi_mode_t'({i_cpol, i_cpha});
                    edge_next = 5'd0;
                    busy_next = 1'b1;
                    if (!i_cpha) mosi_next = i_data[7];
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    edge_next = edge_k;
                    // The final edge always lands on the idle level.
                    sclk_next = (edge_k == LAST_EDGE) ? mode_reg[1] : ~sclk_reg;
                    if (!mode_reg[0]) begin
                        if (edge_k[0]) begin
                            rx_next = {rx_reg[6:0], i_MISO};
                        end else if (edge_k != LAST_EDGE) begin
                            mosi_next = tx_reg[6];
                            tx_next   = {tx_reg[6:0], 1'b0};
                        end
                    end else begin
                        if (edge_k[0]) begin
                            mosi_next = tx_reg[7];
                            tx_next   = {tx_reg[6:0], 1'b0};
                        end else begin
                            rx_next = {rx_reg[6:0], i_MISO};
                        end
                    end
                    if (edge_k == LAST_EDGE) begin
                        busy_next = 1'b0;
                        done_next = 1'b1;
                        data_next = rx_next;
                    end
                end
            end
            default: ;
        endcase
    end

    assign o_busy = busy_reg;
    assign o_done = done_reg;
    assign o_data = data_reg;
    assign o_SCLK = sclk_reg;
    assign o_MOSI = mosi_reg;

endmodule
